mips_cpu: RTL and testbench

- Multicycle, non-pipelined MIPS32 integer-subset CPU with one shared von Neumann memory bus.
- Connects to a 32-bit-wide synchronous RAM with a fixed one-cycle read latency.
- Exposes a run/halt flag (`active`) and a live copy of register $v0 (`register_v0`) so the system bench can check results without reading memory.

---
 rtl/mips_pkg.sv | 67 ++++++
 rtl/mips_regfile.sv | 41 ++++
 rtl/mips_cpu.sv | 231 +++++++++++++++++++++++
 tb/tb_mips_cpu.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS32 subset core: instruction
// field encodings, controller states, ALU operations and the reset vector.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    // Primary opcode field, instruction bits [31:26]
    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LW      = 6'h23,
        OP_SW      = 6'h2B
    } opcode_e;

    // Function field of SPECIAL instructions, bits [5:0]
    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_SRA  = 6'h03,
        F_JR   = 6'h08,
        F_JALR = 6'h09,
        F_ADDU = 6'h21,
        F_SUBU = 6'h23,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2A,
        F_SLTU = 6'h2B
    } funct_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_MEM,
        S_MEMWAIT,
        S_WB,
        S_HALTED
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } alu_op_e;

endpackage

// File: rtl/mips_regfile.sv
// 32 x 32-bit general purpose register file: two combinational read ports,
// one write port, $0 hard-wired to zero and a permanent tap on $2.
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] v0_o
);

    logic [31:0] regs [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_gpr
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_live
                logic [31:0] gpr_q;
                // Load this GPR when the write port addresses it
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        gpr_q <= '0;
                    end else if (we_i && (wa_i == 5'(gi))) begin
                        gpr_q <= wd_i;
                    end
                end
                assign regs[gi] = gpr_q;
            end
        end
    endgenerate

    assign rd1_o = regs[ra1_i];
    assign rd2_o = regs[ra2_i];
    assign v0_o  = regs[2];

endmodule

// File: rtl/mips_cpu.sv
// Multicycle, non-pipelined MIPS32 integer-subset core on a single shared
// memory bus with one-cycle read latency. Each instruction walks
// FETCH -> WAIT -> EXEC -> [MEM -> MEMWAIT] -> WB; taken branches and jumps
// take effect after one delay-slot instruction. Fetching address 0 halts.
module mips_cpu
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] alu_q;         // ALU result / link value / load data / memory address
    logic        take_q;        // current instruction is a taken branch or jump
    logic [31:0] tgt_q;
    logic        pend_q;        // a redirect waits for the delay slot to retire
    logic [31:0] pend_tgt_q;
    logic        active_q;
    logic [31:0] pc_d;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext;
    logic [31:0] rs_data, rt_data;
    logic [31:0] pc_plus4;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};
    assign pc_plus4 = pc_q + 32'd4;

    // Decode outputs
    alu_op_e     alu_op;
    logic [31:0] op_b;
    logic        reg_we;
    logic [4:0]  dest;
    logic        is_load, is_store, is_link, take;
    logic [31:0] target;
    logic [31:0] alu_res;
    logic        reg_we_wb;

    mips_regfile u_regfile (
        .clk   (clk),
        .rst   (reset),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_data),
        .rd2_o (rt_data),
        .we_i  (reg_we_wb),
        .wa_i  (dest),
        .wd_i  (alu_q),
        .v0_o  (register_v0)
    );

    // Decode the latched instruction into ALU, writeback and redirect controls
    always_comb begin
        alu_op   = ALU_ADD;
        op_b     = rt_data;
        reg_we   = 1'b0;
        dest     = rd;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_link  = 1'b0;
        take     = 1'b0;
        target   = pc_plus4 + {imm_sext[29:0], 2'b00};
        case (opcode)
            OP_SPECIAL: begin
                reg_we = 1'b1;
                case (funct)
                    F_ADDU: alu_op = ALU_ADD;
                    F_SUBU: alu_op = ALU_SUB;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_NOR:  alu_op = ALU_NOR;
                    F_SLT:  alu_op = ALU_SLT;
                    F_SLTU: alu_op = ALU_SLTU;
                    F_SLL:  alu_op = ALU_SLL;
                    F_SRL:  alu_op = ALU_SRL;
                    F_SRA:  alu_op = ALU_SRA;
                    F_JR: begin
                        reg_we = 1'b0;
                        take   = 1'b1;
                        target = rs_data;
                    end
                    F_JALR: begin
                        is_link = 1'b1;
                        take    = 1'b1;
                        target  = rs_data;
                    end
                    default: reg_we = 1'b0;  // unknown funct behaves as NOP
                endcase
            end
            OP_J, OP_JAL: begin
                take    = 1'b1;
                target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                reg_we  = (opcode == OP_JAL);
                is_link = (opcode == OP_JAL);
                dest    = 5'd31;
            end
            OP_BEQ:   take = (rs_data == rt_data);
            OP_BNE:   take = (rs_data != rt_data);
            OP_ADDIU: begin alu_op = ALU_ADD;  op_b = imm_sext; reg_we = 1'b1; dest = rt; end
            OP_SLTI:  begin alu_op = ALU_SLT;  op_b = imm_sext; reg_we = 1'b1; dest = rt; end
            OP_SLTIU: begin alu_op = ALU_SLTU; op_b = imm_sext; reg_we = 1'b1; dest = rt; end
            OP_ANDI:  begin alu_op = ALU_AND;  op_b = imm_zext; reg_we = 1'b1; dest = rt; end
            OP_ORI:   begin alu_op = ALU_OR;   op_b = imm_zext; reg_we = 1'b1; dest = rt; end
            OP_XORI:  begin alu_op = ALU_XOR;  op_b = imm_zext; reg_we = 1'b1; dest = rt; end
            OP_LUI:   begin alu_op = ALU_LUI;  op_b = imm_zext; reg_we = 1'b1; dest = rt; end
            OP_LW: begin
                op_b    = imm_sext;
                reg_we  = 1'b1;
                dest    = rt;
                is_load = 1'b1;
            end
            OP_SW: begin
                op_b     = imm_sext;
                is_store = 1'b1;
            end
            default: ;  // undefined opcode: NOP
        endcase
    end

    // ALU: shifts operate on rt, everything else on rs and the selected B operand
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs_data + op_b;
            ALU_SUB:  alu_res = rs_data - op_b;
            ALU_AND:  alu_res = rs_data & op_b;
            ALU_OR:   alu_res = rs_data | op_b;
            ALU_XOR:  alu_res = rs_data ^ op_b;
            ALU_NOR:  alu_res = ~(rs_data | op_b);
            ALU_SLT:  alu_res = {31'd0, $signed(rs_data) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'd0, rs_data < op_b};
            ALU_SLL:  alu_res = op_b << shamt;
            ALU_SRL:  alu_res = op_b >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
            ALU_LUI:  alu_res = {op_b[15:0], 16'h0000};
            default:  alu_res = '0;
        endcase
    end

    // A pending redirect wins over sequential flow once the delay slot retires
    assign pc_d = pend_q ? pend_tgt_q : pc_plus4;

    assign reg_we_wb = (state_q == S_WB) && reg_we;
    assign active    = active_q;
    assign read      = !reset && (((state_q == S_FETCH) && (pc_q != 32'd0)) ||
                                  ((state_q == S_MEM) && is_load));
    assign write     = (state_q == S_MEM) && is_store;
    assign address   = {((state_q == S_MEM) ? alu_q[31:2] : pc_q[31:2]), 2'b00};
    assign writedata = rt_data;

    // Instruction sequencer: advances one state per cycle, commits in WB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_VECTOR;
            ir_q       <= '0;
            alu_q      <= '0;
            take_q     <= 1'b0;
            tgt_q      <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            active_q   <= 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (pc_q == 32'd0) begin
                        state_q  <= S_HALTED;
                        active_q <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    ir_q    <= readdata;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    alu_q   <= is_link ? (pc_q + 32'd8) : alu_res;
                    take_q  <= take;
                    tgt_q   <= target;
                    state_q <= (is_load || is_store) ? S_MEM : S_WB;
                end
                S_MEM: state_q <= S_MEMWAIT;
                S_MEMWAIT: begin
                    if (is_load) begin
                        alu_q <= readdata;
                    end
                    state_q <= S_WB;
                end
                S_WB: begin
                    pc_q       <= pc_d;
                    pend_q     <= take_q;
                    pend_tgt_q <= tgt_q;
                    if (pc_d == 32'd0) begin
                        state_q  <= S_HALTED;
                        active_q <= 1'b0;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: small programs run from a behavioural memory; results
// are observed through register_v0, the bus and memory contents.
module tb_mips_cpu;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata = '0;

    int checks = 0;
    int failures = 0;

    mips_cpu dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .writedata   (writedata),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    // ---------------- memory model and bus monitors ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    logic [31:0] mem [logic [29:0]];
    bus_t        buslog[$];
    int          both_hi = 0;
    int          misaligned = 0;
    int          halted_bus = 0;
    int          falls = 0;
    logic        prev_active = 1'b1;

    always @(posedge clk) begin
        if (read) readdata <= mem.exists(address[31:2]) ? mem[address[31:2]] : 32'h0;
        if (write) mem[address[31:2]] = writedata;
        if ((read || write) && address[31:28] != 4'hB)
            buslog.push_back('{write, address, writedata});
    end

    always @(negedge clk) begin
        if (read && write) both_hi++;
        if ((read || write) && address[1:0] != 2'b00) misaligned++;
        if (!active && !reset && (read || write)) halted_bus++;
        if (prev_active && !active) falls++;
        prev_active = active;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(int op, logic [31:0] tgt);
        return {6'(op), tgt[27:2]};
    endfunction

    localparam logic [31:0] JR0 = 32'h0000_0008;  // jr $0
    localparam logic [31:0] NOP = 32'h0;

    // Operation k: 0..10 are R-type on $t0/$t1 into $v0, 11..17 are I-type on $t0
    function automatic logic [31:0] enc_op(int k, logic [15:0] imm, logic [4:0] sh);
        case (k)
            0:  return enc_r(8, 9, 2, 0, 'h21);
            1:  return enc_r(8, 9, 2, 0, 'h23);
            2:  return enc_r(8, 9, 2, 0, 'h24);
            3:  return enc_r(8, 9, 2, 0, 'h25);
            4:  return enc_r(8, 9, 2, 0, 'h26);
            5:  return enc_r(8, 9, 2, 0, 'h27);
            6:  return enc_r(8, 9, 2, 0, 'h2A);
            7:  return enc_r(8, 9, 2, 0, 'h2B);
            8:  return enc_r(0, 9, 2, int'(sh), 'h00);
            9:  return enc_r(0, 9, 2, int'(sh), 'h02);
            10: return enc_r(0, 9, 2, int'(sh), 'h03);
            11: return enc_i('h09, 8, 2, imm);
            12: return enc_i('h0A, 8, 2, imm);
            13: return enc_i('h0B, 8, 2, imm);
            14: return enc_i('h0C, 8, 2, imm);
            15: return enc_i('h0D, 8, 2, imm);
            16: return enc_i('h0E, 8, 2, imm);
            default: return enc_i('h0F, 0, 2, imm);
        endcase
    endfunction

    // Instruction-level reference: what $v0 must hold after operation k
    function automatic logic [31:0] ref_op(int k, logic [31:0] a, logic [31:0] b,
                                           logic [15:0] imm, logic [4:0] sh);
        logic [31:0] sx;
        logic [31:0] zx;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0, imm};
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7:  return (a < b) ? 32'd1 : 32'd0;
            8:  return b << sh;
            9:  return b >> sh;
            10: return $unsigned($signed(b) >>> sh);
            11: return a + sx;
            12: return ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
            13: return (a < sx) ? 32'd1 : 32'd0;
            14: return a & zx;
            15: return a | zx;
            16: return a ^ zx;
            default: return {imm, 16'h0};
        endcase
    endfunction

    logic [31:0] prog[$];
    logic [31:0] rel_addr;
    logic        rel_read;

    // Load prog at the reset vector, reset, run to halt, then check the halted state
    task automatic run_prog(input string tag, input int exp_cycles);
        logic [29:0] base;
        logic [31:0] v0_at_halt;
        int          cycles;
        base = RV[31:2];
        @(negedge clk);
        reset = 1'b1;
        mem.delete();
        foreach (prog[i]) mem[base + 30'(i)] = prog[i];
        #1;
        buslog.delete();
        falls = 0;
        halted_bus = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        rel_addr = address;
        rel_read = read;
        cycles = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (!active) begin
                cycles = c;
                break;
            end
        end
        check({tag, "_halted"}, {31'd0, active}, 32'd0);
        check({tag, "_cycles"}, cycles, exp_cycles);
        v0_at_halt = register_v0;
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_v0_frozen"}, register_v0, v0_at_halt);
        check({tag, "_active_falls"}, falls, 1);
        check({tag, "_halted_bus"}, halted_bus, 0);
    endtask

    // Materialise a and b in $t0/$t1, apply operation k, halt
    task automatic run_alu(input string tag, input int k, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] imm,
                           input logic [4:0] sh, input logic [31:0] exp);
        prog.delete();
        prog.push_back(enc_i('h0F, 0, 8, a[31:16]));
        prog.push_back(enc_i('h0D, 8, 8, a[15:0]));
        prog.push_back(enc_i('h0F, 0, 9, b[31:16]));
        prog.push_back(enc_i('h0D, 9, 9, b[15:0]));
        prog.push_back(enc_op(k, imm, sh));
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog(tag, 28);
        check({tag, "_v0"}, register_v0, exp);
    endtask

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0,  32'hFFFFFFFF, 32'h1,        16'h0,    5'd0,  32'h00000000};
        vecs[1]  = '{1,  32'h0,        32'h1,        16'h0,    5'd0,  32'hFFFFFFFF};
        vecs[2]  = '{6,  32'h80000000, 32'h1,        16'h0,    5'd0,  32'h00000001};
        vecs[3]  = '{7,  32'h80000000, 32'h1,        16'h0,    5'd0,  32'h00000000};
        vecs[4]  = '{10, 32'h0,        32'h80000000, 16'h0,    5'd4,  32'hF8000000};
        vecs[5]  = '{9,  32'h0,        32'h80000000, 16'h0,    5'd4,  32'h08000000};
        vecs[6]  = '{8,  32'h0,        32'h1,        16'h0,    5'd31, 32'h80000000};
        vecs[7]  = '{5,  32'h0,        32'h0,        16'h0,    5'd0,  32'hFFFFFFFF};
        vecs[8]  = '{13, 32'h5,        32'h0,        16'hFFFF, 5'd0,  32'h00000001};
        vecs[9]  = '{12, 32'h5,        32'h0,        16'hFFFF, 5'd0,  32'h00000000};
        vecs[10] = '{14, 32'hFFFFFFFF, 32'h0,        16'h8000, 5'd0,  32'h00008000};
        vecs[11] = '{16, 32'hFFFF0000, 32'h0,        16'hFFFF, 5'd0,  32'hFFFFFFFF};
        vecs[12] = '{17, 32'h0,        32'h0,        16'h8001, 5'd0,  32'h80010000};
        vecs[13] = '{11, 32'h10,       32'h0,        16'hFFF0, 5'd0,  32'h00000000};

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_v0", register_v0, 32'd0);
        check("rst_read", {31'd0, read}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);

        // ---- reference program ----
        prog.delete();
        prog.push_back(enc_i('h0D, 0, 16, 16'h0010));   // ori $s0,$0,0x10
        prog.push_back(enc_i('h0D, 0, 17, 16'hFFFF));   // ori $s1,$0,0xffff
        prog.push_back(enc_r(0, 17, 18, 0, 'h2A));      // slt $s2,$0,$s1
        prog.push_back(enc_i('h0F, 0, 2, 16'h0001));    // lui $v0,1
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog("basic", 24);
        check("release_addr", rel_addr, RV);
        check("release_read", {31'd0, rel_read}, 32'd1);
        check("basic_v0", register_v0, 32'h00010000);

        // ---- reset while halted ----
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("hrst_active", {31'd0, active}, 32'd1);
        check("hrst_v0", register_v0, 32'd0);
        check("hrst_read", {31'd0, read}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("hrst_addr", address, RV);
        check("hrst_fetch", {31'd0, read}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("hrst_next_fetch", address, RV + 32'd4);

        // ---- same program, saved registers stored to memory ----
        prog.delete();
        prog.push_back(enc_i('h0D, 0, 16, 16'h0010));
        prog.push_back(enc_i('h0D, 0, 17, 16'hFFFF));
        prog.push_back(enc_r(0, 17, 18, 0, 'h2A));
        prog.push_back(enc_i('h0F, 0, 2, 16'h0001));
        prog.push_back(enc_i('h2B, 0, 16, 16'h0100));   // sw $s0,0x100($0)
        prog.push_back(enc_i('h2B, 0, 17, 16'h0104));
        prog.push_back(enc_i('h2B, 0, 18, 16'h0108));
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog("sregs", 42);
        check("s0", mem.exists(30'h40) ? mem[30'h40] : 32'hDEADBEEF, 32'h10);
        check("s1", mem.exists(30'h41) ? mem[30'h41] : 32'hDEADBEEF, 32'hFFFF);
        check("s2", mem.exists(30'h42) ? mem[30'h42] : 32'hDEADBEEF, 32'h1);

        // ---- sign / zero extension ----
        prog.delete();
        prog.push_back(enc_i('h09, 0, 2, 16'hFFFF));    // addiu $v0,$0,-1
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog("addiu_m1", 12);
        check("addiu_m1_v0", register_v0, 32'hFFFFFFFF);
        prog.delete();
        prog.push_back(enc_i('h0D, 0, 2, 16'h8000));    // ori $v0,$0,0x8000
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog("ori_8000", 12);
        check("ori_8000_v0", register_v0, 32'h00008000);

        // ---- store then load ----
        prog.delete();
        prog.push_back(enc_i('h0F, 0, 8, 16'h1234));
        prog.push_back(enc_i('h0D, 8, 8, 16'h5678));
        prog.push_back(enc_i('h0D, 0, 9, 16'h0200));
        prog.push_back(enc_i('h2B, 9, 8, 16'h0000));    // sw $t0,0($t1)
        prog.push_back(enc_i('h23, 9, 2, 16'h0000));    // lw $v0,0($t1)
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog("swlw", 32);
        check("swlw_v0", register_v0, 32'h12345678);
        check("swlw_nacc", buslog.size(), 2);
        if (buslog.size() >= 2) begin
            check("swlw_first_is_write", {31'd0, buslog[0].wr}, 32'd1);
            check("swlw_write_addr", buslog[0].addr, 32'h200);
            check("swlw_write_data", buslog[0].data, 32'h12345678);
            check("swlw_second_is_read", {31'd0, buslog[1].wr}, 32'd0);
            check("swlw_read_addr", buslog[1].addr, 32'h200);
        end

        // ---- branch delay slot ----
        prog.delete();
        prog.push_back(enc_i('h04, 0, 0, 16'h0002));    // beq $0,$0,+2
        prog.push_back(enc_i('h09, 2, 2, 16'h0001));    // delay slot
        prog.push_back(enc_i('h09, 2, 2, 16'h0010));    // skipped
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog("beq", 16);
        check("beq_v0", register_v0, 32'd1);

        prog.delete();
        prog.push_back(enc_i('h05, 0, 0, 16'h0002));    // bne $0,$0 (not taken)
        prog.push_back(enc_i('h09, 2, 2, 16'h0001));
        prog.push_back(enc_i('h09, 2, 2, 16'h0010));
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog("bne_nt", 20);
        check("bne_nt_v0", register_v0, 32'd17);

        prog.delete();
        prog.push_back(enc_j('h03, RV + 32'd12));       // jal to word 3
        prog.push_back(NOP);
        prog.push_back(enc_i('h09, 2, 2, 16'h0010));    // skipped
        prog.push_back(enc_r(31, 0, 2, 0, 'h21));       // addu $v0,$ra,$0
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog("jal", 20);
        check("jal_link", register_v0, RV + 32'd8);

        prog.delete();
        prog.push_back(enc_i('h0F, 0, 8, RV[31:16]));
        prog.push_back(enc_i('h0D, 8, 8, 16'h0018));    // $t0 = word 6
        prog.push_back(enc_r(8, 0, 2, 0, 'h09));        // jalr $v0,$t0
        prog.push_back(NOP);
        prog.push_back(enc_i('h09, 2, 2, 16'h0001));    // skipped
        prog.push_back(NOP);
        prog.push_back(JR0);
        prog.push_back(NOP);
        run_prog("jalr", 24);
        check("jalr_link", register_v0, RV + 32'd16);

        // ---- table vectors ----
        foreach (vecs[i])
            run_alu($sformatf("vec%0d", i), vecs[i].k, vecs[i].a, vecs[i].b,
                    vecs[i].imm, vecs[i].sh, vecs[i].exp);

        // ---- randomized operations against the reference model ----
        for (int i = 0; i < 16; i++) begin
            int          k;
            logic [31:0] a;
            logic [31:0] b;
            logic [15:0] imm;
            logic [4:0]  sh;
            k   = int'($urandom_range(0, 17));
            a   = $urandom;
            b   = $urandom;
            imm = 16'($urandom);
            sh  = 5'($urandom);
            run_alu($sformatf("rnd%0d_k%0d", i, k), k, a, b, imm, sh, ref_op(k, a, b, imm, sh));
        end

        check("bus_read_write_overlap", both_hi, 0);
        check("bus_misaligned", misaligned, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
